// File: rtl/lab_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lab_pkg
//  Description : Shared types and constants for the parameter-edit UI.
//                UI mode encoding, KEY bit assignments and autorepeat timing
//                (the latter used only when PARAM_AUTOREPEAT_EN is defined).
//  Revision    : 1.0  initial release
// ============================================================================
package lab_pkg;

    typedef enum logic [1:0] {
        UI_SEL_FX    = 2'd0,
        UI_SEL_PARAM = 2'd1,
        UI_EDIT      = 2'd2
    } ui_mode_t;

    localparam int KEY_INC_IDX  = 0;
    localparam int KEY_DEC_IDX  = 1;
    localparam int KEY_NEXT_IDX = 2;
    localparam int KEY_BACK_IDX = 3;

    // Hold time before the first repeat step, then the repeat period.
    localparam int AUTOREPEAT_HOLD_CYC = 25_000_000;
    localparam int AUTOREPEAT_RATE_CYC = 5_000_000;
    localparam int AUTOREPEAT_CNT_W    = $clog2(AUTOREPEAT_HOLD_CYC);

endpackage : lab_pkg
`default_nettype wire

// File: rtl/key_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : key_edge_detect
//  Description : Per-key two-flop synchroniser for active-low push buttons
//                with a press pulse (registered high->low edge) and a
//                synchronised "held" level.
//  Ports       : clk_i      - clock
//                rst_ni     - synchronous active-low reset
//                key_n_i    - raw active-low keys
//                press_o    - one-cycle pulse per push
//                held_o     - 1 while the synchronised key is down
//  Revision    : 1.0  initial release
// ============================================================================
module key_edge_detect #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] key_n_i,
    output logic [N-1:0] press_o,
    output logic [N-1:0] held_o
);

    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;
    logic [N-1:0] prev_q;

    // Reset to "released" so a key already down at reset is not a press.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Pulse is high in the cycle after the second sync stage sees the key
    // down, so the controller acts on the third edge after first sampling.
    assign press_o = prev_q & ~sync2_q;
    assign held_o  = ~sync2_q;

endmodule : key_edge_detect
`default_nettype wire

// File: rtl/param_edit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : param_edit_ctrl
//  Description : Parameter-edit UI controller for the effects chain. KEY
//                presses select effect/parameter and edit values; the
//                parameter store lives here; committed edits go out over a
//                valid/ready write port.
//  Ports       : CLOCK_50, reset_n (sync, active-low), KEY[3:0] (active-low:
//                INC, DEC, NEXT, BACK), SW[9:0] (SW[1] coarse step),
//                fx_sel/param_sel/current_value/ui_mode/dirty -> display,
//                wr_valid/wr_ready/wr_fx/wr_param/wr_data -> FX datapath.
//  Options     : PARAM_AUTOREPEAT_EN - held INC/DEC repeats in UI_EDIT.
//  Revision    : 1.0  initial release
// ============================================================================
module param_edit_ctrl
    import lab_pkg::*;
#(
    parameter int FX_COUNT    = 16,
    parameter int PARAM_COUNT = 8,
    parameter int PARAM_W     = 8,
    parameter int PARAM_INIT  = 128,
    parameter int COARSE_STEP = 16,
    localparam int FXW = $clog2(FX_COUNT),
    localparam int PXW = $clog2(PARAM_COUNT)
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic [3:0]         KEY,
    input  logic [9:0]         SW,
    output logic [FXW-1:0]     fx_sel,
    output logic [PXW-1:0]     param_sel,
    output logic [PARAM_W-1:0] current_value,
    output logic [1:0]         ui_mode,
    output logic               dirty,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [FXW-1:0]     wr_fx,
    output logic [PXW-1:0]     wr_param,
    output logic [PARAM_W-1:0] wr_data
);

    localparam logic [FXW-1:0]     FX_MAX   = FXW'(FX_COUNT - 1);
    localparam logic [PXW-1:0]     PAR_MAX  = PXW'(PARAM_COUNT - 1);
    localparam logic [PARAM_W-1:0] VAL_INIT = PARAM_W'(PARAM_INIT);

    // ------------------------------------------------------------------
    // Key synchronisation
    // ------------------------------------------------------------------
    logic [3:0] key_press;
    logic [3:0] key_held;

    key_edge_detect #(.N(4)) u_keys (
        .clk_i   (CLOCK_50),
        .rst_ni  (reset_n),
        .key_n_i (KEY),
        .press_o (key_press),
        .held_o  (key_held)
    );

    // Priority: BACK > NEXT > INC/DEC; INC with DEC cancels out.
    logic ev_back, ev_next, ev_inc, ev_dec;
    assign ev_back = key_press[KEY_BACK_IDX];
    assign ev_next = key_press[KEY_NEXT_IDX] & ~ev_back;
    assign ev_inc  = key_press[KEY_INC_IDX] & ~key_press[KEY_DEC_IDX] & ~ev_back & ~ev_next;
    assign ev_dec  = key_press[KEY_DEC_IDX] & ~key_press[KEY_INC_IDX] & ~ev_back & ~ev_next;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    ui_mode_t             state_q, state_d;
    logic [FXW-1:0]       fx_q, fx_d;
    logic [PXW-1:0]       param_q, param_d;
    logic [PARAM_W-1:0]   edit_q, edit_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [FXW-1:0]       wr_fx_q, wr_fx_d;
    logic [PXW-1:0]       wr_param_q, wr_param_d;
    logic [PARAM_W-1:0]   wr_data_q, wr_data_d;
    logic                 commit;

    logic [PARAM_W-1:0]   store_q [FX_COUNT][PARAM_COUNT];
    logic [PARAM_W-1:0]   stored_val;

    assign stored_val = store_q[fx_q][param_q];

    // ------------------------------------------------------------------
    // Saturating step arithmetic (one extra bit catches carry/borrow)
    // ------------------------------------------------------------------
    logic [PARAM_W-1:0] step;
    logic [PARAM_W:0]   inc_sum;
    logic [PARAM_W:0]   dec_diff;
    logic [PARAM_W-1:0] inc_val;
    logic [PARAM_W-1:0] dec_val;

    assign step     = SW[1] ? PARAM_W'(COARSE_STEP) : PARAM_W'(1);
    assign inc_sum  = {1'b0, edit_q} + {1'b0, step};
    assign dec_diff = {1'b0, edit_q} - {1'b0, step};
    assign inc_val  = inc_sum[PARAM_W]  ? '1 : inc_sum[PARAM_W-1:0];
    assign dec_val  = dec_diff[PARAM_W] ? '0 : dec_diff[PARAM_W-1:0];

    // ------------------------------------------------------------------
    // Optional autorepeat of held INC/DEC while editing
    // ------------------------------------------------------------------
    logic rep_inc, rep_dec;

`ifdef PARAM_AUTOREPEAT_EN
    logic [AUTOREPEAT_CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic                        rep_armed_q, rep_armed_d;
    logic                        rep_fire;
    logic                        rep_active;
    logic [AUTOREPEAT_CNT_W-1:0] rep_limit;

    // Exactly one of INC/DEC held, and only in UI_EDIT; anything else
    // (release, both held, mode change) clears the counter.
    assign rep_active = (state_q == UI_EDIT) &&
                        (key_held[KEY_INC_IDX] ^ key_held[KEY_DEC_IDX]);
    assign rep_limit  = rep_armed_q ? AUTOREPEAT_CNT_W'(AUTOREPEAT_RATE_CYC - 1)
                                    : AUTOREPEAT_CNT_W'(AUTOREPEAT_HOLD_CYC - 1);

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        if (!rep_active) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (rep_cnt_q == rep_limit) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b1;
        end else begin
            rep_cnt_d   = rep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end

    assign rep_inc = rep_fire & key_held[KEY_INC_IDX];
    assign rep_dec = rep_fire & key_held[KEY_DEC_IDX];
`else
    assign rep_inc = 1'b0;
    assign rep_dec = 1'b0;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{SW[9:2], SW[0], key_held};

    // ------------------------------------------------------------------
    // Next-state / datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fx_d       = fx_q;
        param_d    = param_q;
        edit_d     = edit_q;
        wr_valid_d = wr_valid_q;
        wr_fx_d    = wr_fx_q;
        wr_param_d = wr_param_q;
        wr_data_d  = wr_data_q;
        commit     = 1'b0;

        if (wr_valid_q && wr_ready) begin
            wr_valid_d = 1'b0;
        end

        case (state_q)
            UI_SEL_FX: begin
                if (ev_back) begin
                    state_d = UI_SEL_FX;
                end else if (ev_next) begin
                    state_d = UI_SEL_PARAM;
                end else if (ev_inc) begin
                    fx_d = (fx_q == FX_MAX) ? '0 : fx_q + 1'b1;
                end else if (ev_dec) begin
                    fx_d = (fx_q == '0) ? FX_MAX : fx_q - 1'b1;
                end
            end

            UI_SEL_PARAM: begin
                if (ev_back) begin
                    state_d = UI_SEL_FX;
                end else if (ev_next) begin
                    state_d = UI_EDIT;
                    edit_d  = stored_val;
                end else if (ev_inc) begin
                    param_d = (param_q == PAR_MAX) ? '0 : param_q + 1'b1;
                end else if (ev_dec) begin
                    param_d = (param_q == '0) ? PAR_MAX : param_q - 1'b1;
                end
            end

            UI_EDIT: begin
                if (ev_back) begin
                    state_d = UI_SEL_PARAM;
                end else if (ev_next) begin
                    // A commit while the previous write is outstanding is
                    // ignored so the held write payload never changes.
                    if (!wr_valid_q) begin
                        commit     = 1'b1;
                        state_d    = UI_SEL_PARAM;
                        wr_valid_d = 1'b1;
                        wr_fx_d    = fx_q;
                        wr_param_d = param_q;
                        wr_data_d  = edit_q;
                    end
                end else if (ev_inc || rep_inc) begin
                    edit_d = inc_val;
                end else if (ev_dec || rep_dec) begin
                    edit_d = dec_val;
                end
            end

            default: begin
                state_d = UI_SEL_FX;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q    <= UI_SEL_FX;
            fx_q       <= '0;
            param_q    <= '0;
            edit_q     <= VAL_INIT;
            wr_valid_q <= 1'b0;
            wr_fx_q    <= '0;
            wr_param_q <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            fx_q       <= fx_d;
            param_q    <= param_d;
            edit_q     <= edit_d;
            wr_valid_q <= wr_valid_d;
            wr_fx_q    <= wr_fx_d;
            wr_param_q <= wr_param_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            for (int f = 0; f < FX_COUNT; f++) begin
                for (int p = 0; p < PARAM_COUNT; p++) begin
                    store_q[f][p] <= VAL_INIT;
                end
            end
        end else if (commit) begin
            store_q[fx_q][param_q] <= edit_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fx_sel        = fx_q;
    assign param_sel     = param_q;
    assign ui_mode       = state_q;
    assign wr_valid      = wr_valid_q;
    assign wr_fx         = wr_fx_q;
    assign wr_param      = wr_param_q;
    assign wr_data       = wr_data_q;
    assign current_value = (state_q == UI_EDIT) ? edit_q : stored_val;
    assign dirty         = (state_q == UI_EDIT) && (edit_q != stored_val);

endmodule : param_edit_ctrl
`default_nettype wire

// File: tb/tb_param_edit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_edit_ctrl
//  Description : Self-checking bench for param_edit_ctrl. A behavioural
//                model of the UI rules runs alongside the DUT and is compared
//                every cycle; directed literal checks pin the model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_edit_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] KEY = 4'hF;
    logic [9:0] SW = '0;
    logic       wr_ready = 1'b0;

    logic [3:0] fx_sel;
    logic [2:0] param_sel;
    logic [7:0] current_value;
    logic [1:0] ui_mode;
    logic       dirty;
    logic       wr_valid;
    logic [3:0] wr_fx;
    logic [2:0] wr_param;
    logic [7:0] wr_data;

    param_edit_ctrl dut (
        .CLOCK_50      (clk),
        .reset_n       (reset_n),
        .KEY           (KEY),
        .SW            (SW),
        .fx_sel        (fx_sel),
        .param_sel     (param_sel),
        .current_value (current_value),
        .ui_mode       (ui_mode),
        .dirty         (dirty),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_fx         (wr_fx),
        .wr_param      (wr_param),
        .wr_data       (wr_data)
    );

    always #10 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: mode 0=select fx, 1=select param, 2=edit
    // ------------------------------------------------------------------
    bit         started = 1'b0;
    int         m_mode, m_fx, m_param, m_edit;
    int         m_store [16][8];
    bit         m_valid;
    int         m_wfx, m_wparam, m_wdata;
    logic [3:0] h1 = 4'hF, h2 = 4'hF, h3 = 4'hF;  // KEY sampled 1/2/3 edges ago

    always @(posedge clk) begin : model
        logic [3:0] pr;
        bit         old_v;
        int         step, d, v;
        if (!reset_n) begin
            started = 1'b1;
            m_mode = 0; m_fx = 0; m_param = 0; m_edit = 128;
            for (int f = 0; f < 16; f++)
                for (int p = 0; p < 8; p++) m_store[f][p] = 128;
            m_valid = 1'b0; m_wfx = 0; m_wparam = 0; m_wdata = 0;
            h1 = 4'hF; h2 = 4'hF; h3 = 4'hF;
        end else begin
            // A push takes effect on the third edge after it is first sampled.
            pr = h3 & ~h2;
            h3 = h2; h2 = h1; h1 = KEY;
            old_v = m_valid;
            if (m_valid && wr_ready) m_valid = 1'b0;
            step = SW[1] ? 16 : 1;
            if (pr[3]) begin
                if (m_mode == 1) m_mode = 0;
                else if (m_mode == 2) m_mode = 1;
            end else if (pr[2]) begin
                if (m_mode == 0) m_mode = 1;
                else if (m_mode == 1) begin
                    m_edit = m_store[m_fx][m_param];
                    m_mode = 2;
                end else if (!old_v) begin
                    m_store[m_fx][m_param] = m_edit;
                    m_valid = 1'b1;
                    m_wfx = m_fx; m_wparam = m_param; m_wdata = m_edit;
                    m_mode = 1;
                end
            end else if (pr[0] != pr[1]) begin
                d = pr[0] ? 1 : -1;
                if (m_mode == 0) m_fx = (m_fx + d + 16) % 16;
                else if (m_mode == 1) m_param = (m_param + d + 8) % 8;
                else begin
                    v = m_edit + d * step;
                    m_edit = (v > 255) ? 255 : (v < 0) ? 0 : v;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int exp_cur;
        if (started && reset_n) begin
            exp_cur = (m_mode == 2) ? m_edit : m_store[m_fx][m_param];
            chk("fx_sel", fx_sel, m_fx);
            chk("param_sel", param_sel, m_param);
            chk("ui_mode", ui_mode, m_mode);
            chk("current_value", current_value, exp_cur);
            chk("dirty", dirty, (m_mode == 2) && (m_edit != m_store[m_fx][m_param]));
            chk("wr_valid", wr_valid, m_valid);
            chk("wr_fx", wr_fx, m_wfx);
            chk("wr_param", wr_param, m_wparam);
            chk("wr_data", wr_data, m_wdata);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic press(input logic [3:0] mask, input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            KEY = ~mask;
            repeat (4) @(negedge clk);
            KEY = 4'hF;
            repeat (4) @(negedge clk);
        end
    endtask

    localparam logic [3:0] K_INC = 4'b0001, K_DEC = 4'b0010,
                           K_NEXT = 4'b0100, K_BACK = 4'b1000;

    initial begin
        // Reset
        @(negedge clk); reset_n = 1'b0;
        repeat (3) @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        chk("rst fx_sel", fx_sel, 0);
        chk("rst ui_mode", ui_mode, 0);
        chk("rst current_value", current_value, 128);
        chk("rst wr_valid", wr_valid, 0);

        // 1: fx wrap both ways
        press(K_INC, 17);
        chk("t1 fx after 17 INC", fx_sel, 1);
        press(K_DEC, 2);
        chk("t1 fx DEC wrap", fx_sel, 15);
        press(K_INC, 4);
        chk("t1 fx=3", fx_sel, 3);

        // 2: coarse saturation
        press(K_NEXT);
        press(K_INC, 5);
        chk("t2 param=5", param_sel, 5);
        press(K_NEXT);
        SW[1] = 1'b1;
        press(K_INC, 8);
        chk("t2 saturated", current_value, 255);
        chk("t2 dirty", dirty, 1);

        // 3: commit held against wr_ready=0, NEXT ignored while pending
        press(K_NEXT);
        repeat (10) @(negedge clk);
        chk("t3 wr_valid", wr_valid, 1);
        chk("t3 wr_fx", wr_fx, 3);
        chk("t3 wr_param", wr_param, 5);
        chk("t3 wr_data", wr_data, 255);
        press(K_NEXT);
        press(K_NEXT);
        chk("t3 NEXT ignored while pending", ui_mode, 2);
        wr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3 wr_valid dropped", wr_valid, 0);
        press(K_BACK);
        chk("t3 stored 255", current_value, 255);

        // 4: cancel discards edit
        SW[1] = 1'b0;
        press(K_INC);
        press(K_NEXT);
        press(K_DEC, 3);
        chk("t4 edit 125", current_value, 125);
        press(K_BACK);
        chk("t4 mode after cancel", ui_mode, 1);
        chk("t4 value after cancel", current_value, 128);
        chk("t4 no write", wr_valid, 0);

        // 5: simultaneous keys
        press(K_INC | K_DEC);
        chk("t5 INC+DEC no-op", param_sel, 6);
        press(K_NEXT);
        press(K_INC);
        press(K_BACK | K_NEXT);
        chk("t5 BACK wins mode", ui_mode, 1);
        chk("t5 BACK wins value", current_value, 128);
        // unchanged-value commit still writes (ready held high)
        press(K_NEXT);
        press(K_NEXT);

        // 6: reset drops a pending write
        wr_ready = 1'b0;
        press(K_NEXT);
        press(K_NEXT);
        chk("t6 pending before reset", wr_valid, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6 wr_valid reset", wr_valid, 0);
        chk("t6 fx reset", fx_sel, 0);
        chk("t6 param reset", param_sel, 0);
        reset_n = 1'b1;
        press(K_INC, 3);
        press(K_NEXT);
        press(K_INC, 5);
        chk("t6 store[3][5] reset", current_value, 128);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_param_edit_ctrl
`default_nettype wire
